// File: rtl/piso_pkg.sv
// Shared types and defaults for the piso_tx parallel-in serial-out transmitter.
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } piso_state_t;

    localparam int PISO_WIDTH_DEF = 8;

endpackage

// File: rtl/piso_hold.sv
// Single-entry word buffer in front of the shifter; a write and a read never
// coincide because the writer is only ready while the buffer is empty.
module piso_hold #(
    parameter int WIDTH = piso_pkg::PISO_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             valid
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
        end else begin
            valid <= (valid && !rd_en) || wr_en;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            dout <= din;
        end
    end

endmodule

// File: rtl/piso_tx.sv
// Serializer feeding sipo_1: valid/ready word input, one-word hold buffer,
// registered data_out/load stream with a programmable idle gap between words.
module piso_tx #(
    parameter int WIDTH     = piso_pkg::PISO_WIDTH_DEF,
    parameter int GAP       = 2,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             data_out,
    output logic             load,
    output logic             busy,
    output logic             done
);

    import piso_pkg::*;

    localparam int BW = $clog2(WIDTH);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = (GAP > 0) ? GW'(GAP - 1) : '0;

    piso_state_t      state, state_nxt;
    logic [WIDTH-1:0] sr, sr_nxt;
    logic [BW-1:0]    bit_cnt, bit_cnt_nxt;
    logic [GW-1:0]    gap_cnt, gap_cnt_nxt;
    logic [WIDTH-1:0] hold_data;
    logic             hold_valid;
    logic             hold_wr, hold_rd;
    logic             accept;
    logic             load_nxt, data_out_nxt, busy_nxt, done_nxt;

    function automatic logic lead_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    assign in_ready = !hold_valid;
    assign accept   = in_valid && in_ready;
    // In IDLE an accepted word bypasses the buffer straight into the shifter.
    assign hold_wr  = accept && (state != piso_pkg::IDLE);

    piso_hold #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk   (clk),
        .rst   (rst),
        .wr_en (hold_wr),
        .rd_en (hold_rd),
        .din   (in_data),
        .dout  (hold_data),
        .valid (hold_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= piso_pkg::IDLE;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            load     <= 1'b0;
            data_out <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            gap_cnt  <= gap_cnt_nxt;
            load     <= load_nxt;
            data_out <= data_out_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
        end
    end

    always_ff @(posedge clk) begin
        sr <= sr_nxt;
    end

    always_comb begin
        state_nxt   = state;
        sr_nxt      = sr;
        bit_cnt_nxt = bit_cnt;
        gap_cnt_nxt = gap_cnt;
        hold_rd     = 1'b0;
        case (state)
            piso_pkg::IDLE: begin
                if (hold_valid) begin
                    sr_nxt      = hold_data;
                    hold_rd     = 1'b1;
                    bit_cnt_nxt = '0;
                    state_nxt   = piso_pkg::SHIFT;
                end else if (accept) begin
                    sr_nxt      = in_data;
                    bit_cnt_nxt = '0;
                    state_nxt   = piso_pkg::SHIFT;
                end
            end
            piso_pkg::SHIFT: begin
                if (bit_cnt == BIT_LAST) begin
                    if (GAP > 0) begin
                        gap_cnt_nxt = '0;
                        state_nxt   = piso_pkg::GAP;
                    end else if (hold_valid) begin
                        // Zero gap: next word's first bit follows immediately.
                        sr_nxt      = hold_data;
                        hold_rd     = 1'b1;
                        bit_cnt_nxt = '0;
                    end else begin
                        state_nxt = piso_pkg::IDLE;
                    end
                end else begin
                    sr_nxt      = advance(sr);
                    bit_cnt_nxt = bit_cnt + 1'b1;
                end
            end
            piso_pkg::GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    if (hold_valid) begin
                        sr_nxt      = hold_data;
                        hold_rd     = 1'b1;
                        bit_cnt_nxt = '0;
                        state_nxt   = piso_pkg::SHIFT;
                    end else begin
                        state_nxt = piso_pkg::IDLE;
                    end
                end else begin
                    gap_cnt_nxt = gap_cnt + 1'b1;
                end
            end
            default: state_nxt = piso_pkg::IDLE;
        endcase
    end

    // Outputs are registered copies of what the next state will present.
    always_comb begin
        load_nxt     = (state_nxt == piso_pkg::SHIFT);
        data_out_nxt = load_nxt && lead_bit(sr_nxt);
        busy_nxt     = (state_nxt != piso_pkg::IDLE);
        done_nxt     = load_nxt && (bit_cnt_nxt == BIT_LAST);
    end

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: three parameterisations plus a sipo_1 loopback model.
module tb_piso_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
    logic [7:0] d0 = '0, d1 = '0, d2 = '0;
    logic       r0, r1, r2, do0, do1, do2, ld0, ld1, ld2, bz0, bz1, bz2, dn0, dn1, dn2;

    piso_tx #(.WIDTH(8), .GAP(2), .MSB_FIRST(1'b1)) u_gap2 (
        .clk(clk), .rst(rst), .in_valid(v0), .in_data(d0), .in_ready(r0),
        .data_out(do0), .load(ld0), .busy(bz0), .done(dn0));

    piso_tx #(.WIDTH(8), .GAP(0), .MSB_FIRST(1'b1)) u_gap0 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_data(d1), .in_ready(r1),
        .data_out(do1), .load(ld1), .busy(bz1), .done(dn1));

    piso_tx #(.WIDTH(8), .GAP(2), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .in_valid(v2), .in_data(d2), .in_ready(r2),
        .data_out(do2), .load(ld2), .busy(bz2), .done(dn2));

    // Receiver model of sipo_1: shifts in at the LSB while load is high.
    logic [7:0] sq;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sq <= '0;
        else if (ld0) sq <= {sq[6:0], do0};
    end

    int         n_tests = 0;
    int         n_fail  = 0;
    logic       exp_q[$];
    logic [7:0] byte_q[$];
    logic       tr_ld[64], tr_do[64], tr_dn[64], tr_bz[64], tr_rdy[64];
    logic [7:0] tr_sq[64];

    function automatic logic rdy_of(input int w);
        case (w)
            0: return r0;
            1: return r1;
            default: return r2;
        endcase
    endfunction

    task automatic set_in(input int w, input logic v, input logic [7:0] d);
        case (w)
            0: begin v0 = v; d0 = d; end
            1: begin v1 = v; d1 = d; end
            default: begin v2 = v; d2 = d; end
        endcase
    endtask

    // Offers one byte until accepted; pushes its expected serial bits on acceptance.
    task automatic drive(input int w, input logic [7:0] b);
        logic ok;
        ok = 1'b0;
        set_in(w, 1'b1, b);
        for (int t = 0; t < 100; t++) begin
            ok = rdy_of(w);
            @(posedge clk);
            #1;
            if (ok) break;
        end
        set_in(w, 1'b0, 8'h00);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL drive_accept w=%0d byte=%h: in_ready never seen high", w, b);
        end else begin
            for (int j = 0; j < 8; j++) exp_q.push_back((w == 2) ? b[j] : b[7-j]);
            byte_q.push_back(b);
        end
    endtask

    task automatic capture(input int w, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            case (w)
                0: begin tr_ld[i] = ld0; tr_do[i] = do0; tr_dn[i] = dn0; tr_bz[i] = bz0; tr_rdy[i] = r0; end
                1: begin tr_ld[i] = ld1; tr_do[i] = do1; tr_dn[i] = dn1; tr_bz[i] = bz1; tr_rdy[i] = r1; end
                default: begin tr_ld[i] = ld2; tr_do[i] = do2; tr_dn[i] = dn2; tr_bz[i] = bz2; tr_rdy[i] = r2; end
            endcase
            tr_sq[i] = sq;
        end
    endtask

    function automatic logic [63:0] vec(input int kind, input int n);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < n; i++) begin
            case (kind)
                0: v[i] = tr_ld[i];
                1: v[i] = tr_do[i];
                2: v[i] = tr_dn[i];
                3: v[i] = tr_bz[i];
                default: v[i] = tr_rdy[i];
            endcase
        end
        return v;
    endfunction

    task automatic test_reset;
        logic [4:0] got;
        #2 rst = 1'b0;
        #10;
        for (int w = 0; w < 3; w++) begin
            case (w)
                0: got = {ld0, do0, dn0, bz0, r0};
                1: got = {ld1, do1, dn1, bz1, r1};
                default: got = {ld2, do2, dn2, bz2, r2};
            endcase
            n_tests++;
            if (got !== 5'b00001) begin
                n_fail++;
                $display("FAIL reset_state w=%0d got {ld,do,dn,bz,rdy}=%b want 00001", w, got);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        got = {ld0, do0, dn0, bz0, r0};
        n_tests++;
        if (got !== 5'b00001) begin
            n_fail++;
            $display("FAIL post_reset_idle got {ld,do,dn,bz,rdy}=%b want 00001", got);
        end
    endtask

    task automatic test_single;
        logic e;
        exp_q.delete();
        fork
            drive(0, 8'hF0);
            capture(0, 14);
        join
        for (int i = 0; i < 14; i++) if (tr_ld[i]) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++; $display("FAIL single_bit idx=%0d got=%b want none", i, tr_do[i]);
            end else begin
                e = exp_q.pop_front();
                if (tr_do[i] !== e) begin n_fail++; $display("FAIL single_bit idx=%0d got=%b want %b", i, tr_do[i], e); end
            end
        end
        n_tests++;
        if (vec(0, 14) !== 64'h00FF) begin n_fail++; $display("FAIL single_load got=%h want 00ff", vec(0, 14)); end
        n_tests++;
        if (vec(1, 14) !== 64'h000F) begin n_fail++; $display("FAIL single_data got=%h want 000f", vec(1, 14)); end
        n_tests++;
        if (vec(2, 14) !== 64'h0080) begin n_fail++; $display("FAIL single_done got=%h want 0080", vec(2, 14)); end
        n_tests++;
        if (vec(3, 14) !== 64'h03FF) begin n_fail++; $display("FAIL single_busy got=%h want 03ff", vec(3, 14)); end
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL single_drain got=%0d left want 0", exp_q.size()); end
    endtask

    task automatic test_queued;
        logic e;
        exp_q.delete();
        fork
            begin drive(0, 8'hAA); drive(0, 8'hFF); end
            capture(0, 22);
        join
        for (int i = 0; i < 22; i++) if (tr_ld[i]) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++; $display("FAIL queued_bit idx=%0d got=%b want none", i, tr_do[i]);
            end else begin
                e = exp_q.pop_front();
                if (tr_do[i] !== e) begin n_fail++; $display("FAIL queued_bit idx=%0d got=%b want %b", i, tr_do[i], e); end
            end
        end
        n_tests++;
        if (vec(0, 22) !== 64'h3FCFF) begin n_fail++; $display("FAIL queued_load got=%h want 3fcff", vec(0, 22)); end
        n_tests++;
        if (vec(4, 22) !== 64'h3FFC01) begin n_fail++; $display("FAIL queued_ready got=%h want 3ffc01", vec(4, 22)); end
        n_tests++;
        if (vec(2, 22) !== 64'h20080) begin n_fail++; $display("FAIL queued_done got=%h want 20080", vec(2, 22)); end
        n_tests++;
        if (vec(3, 22) !== 64'hFFFFF) begin n_fail++; $display("FAIL queued_busy got=%h want fffff", vec(3, 22)); end
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL queued_drain got=%0d left want 0", exp_q.size()); end
    endtask

    task automatic test_gap0;
        logic e;
        exp_q.delete();
        fork
            begin drive(1, 8'h5A); drive(1, 8'hC3); end
            capture(1, 20);
        join
        for (int i = 0; i < 20; i++) if (tr_ld[i]) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++; $display("FAIL gap0_bit idx=%0d got=%b want none", i, tr_do[i]);
            end else begin
                e = exp_q.pop_front();
                if (tr_do[i] !== e) begin n_fail++; $display("FAIL gap0_bit idx=%0d got=%b want %b", i, tr_do[i], e); end
            end
        end
        n_tests++;
        if (vec(0, 20) !== 64'h0FFFF) begin n_fail++; $display("FAIL gap0_load got=%h want 0ffff", vec(0, 20)); end
        n_tests++;
        if (vec(2, 20) !== 64'h08080) begin n_fail++; $display("FAIL gap0_done got=%h want 08080", vec(2, 20)); end
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL gap0_drain got=%0d left want 0", exp_q.size()); end
    endtask

    task automatic test_lsb_first;
        logic e;
        exp_q.delete();
        fork
            drive(2, 8'h01);
            capture(2, 12);
        join
        for (int i = 0; i < 12; i++) if (tr_ld[i]) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++; $display("FAIL lsb_bit idx=%0d got=%b want none", i, tr_do[i]);
            end else begin
                e = exp_q.pop_front();
                if (tr_do[i] !== e) begin n_fail++; $display("FAIL lsb_bit idx=%0d got=%b want %b", i, tr_do[i], e); end
            end
        end
        n_tests++;
        if (vec(0, 12) !== 64'h0FF) begin n_fail++; $display("FAIL lsb_load got=%h want 0ff", vec(0, 12)); end
        n_tests++;
        if (vec(1, 12) !== 64'h001) begin n_fail++; $display("FAIL lsb_data got=%h want 001", vec(1, 12)); end
    endtask

    task automatic test_reset_mid;
        logic [4:0] got;
        fork
            begin drive(0, 8'hAA); drive(0, 8'hFF); end
        join
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if ({ld0, r0} !== 2'b10) begin
            n_fail++; $display("FAIL mid_before got {ld,rdy}=%b want 10", {ld0, r0});
        end
        rst = 1'b0;
        #1;
        got = {ld0, do0, dn0, bz0, r0};
        n_tests++;
        if (got !== 5'b00001) begin
            n_fail++; $display("FAIL mid_async got {ld,do,dn,bz,rdy}=%b want 00001", got);
        end
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        byte_q.delete();
        capture(0, 20);
        n_tests++;
        if (vec(0, 20) !== 64'h0) begin n_fail++; $display("FAIL mid_residual_load got=%h want 0", vec(0, 20)); end
        n_tests++;
        if (vec(3, 20) !== 64'h0) begin n_fail++; $display("FAIL mid_busy got=%h want 0", vec(3, 20)); end
        n_tests++;
        if (vec(4, 20) !== 64'hFFFFF) begin n_fail++; $display("FAIL mid_ready got=%h want fffff", vec(4, 20)); end
    endtask

    task automatic test_loopback;
        int         n_done;
        logic [7:0] e;
        exp_q.delete();
        byte_q.delete();
        n_done = 0;
        fork
            begin drive(0, 8'hF0); drive(0, 8'hAA); drive(0, 8'hFF); end
            capture(0, 34);
        join
        for (int i = 0; i < 33; i++) if (tr_dn[i]) begin
            n_done++;
            n_tests++;
            if (byte_q.size() == 0) begin
                n_fail++; $display("FAIL loop_word idx=%0d got=%h want none", i, tr_sq[i+1]);
            end else begin
                e = byte_q.pop_front();
                if (tr_sq[i+1] !== e) begin n_fail++; $display("FAIL loop_word idx=%0d got=%h want %h", i, tr_sq[i+1], e); end
            end
        end
        n_tests++;
        if (n_done != 3) begin n_fail++; $display("FAIL loop_done_count got=%0d want 3", n_done); end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_queued();
        test_gap0();
        test_lsb_first();
        test_reset_mid();
        test_loopback();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/piso_tx.md
# piso_tx

Parallel-in serial-out transmitter that sits directly upstream of `sipo_1`. It accepts bytes on a valid/ready handshake and holds one queued word in a single-entry buffer. It drives the serial `data_out`/`load` pair that `sipo_1` consumes, one bit per `clk` cycle, with a programmable idle gap between words.

## Interface
- `WIDTH`, 8: word width in bits; must be ≥ 2.
- `GAP`, 2: idle cycles with `load` low inserted after each word; 0 means back-to-back words.
- `MSB_FIRST`, 1: bit order. 1 sends bit `WIDTH-1` first, which matches `sipo_1`: it shifts in at the LSB and moves earlier bits toward the MSB.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream word valid.
- `in_data`  in  WIDTH  upstream word.
- `in_ready`  out  1  block can accept a word this cycle.
- `data_out`  out  1  serial bit; connects to `sipo_1` `data_in`.
- `load`  out  1  serial bit valid; connects to `sipo_1` `load`.
- `busy`  out  1  high in SHIFT or GAP.
- `done`  out  1  one-cycle pulse concurrent with the last bit of a word.

## Operation
- **Storage:**
  - shift register `sr` [WIDTH];
  - bit counter `bit_cnt` [$clog2(WIDTH)];
  - gap counter `gap_cnt` [$clog2(GAP+1)];
  - hold buffer `hold_data` and `hold_valid`.
- **Handshake:**
  - `in_ready = !hold_valid`, combinational from a register.
  - A transfer occurs on a rising edge with `in_valid && in_ready`.
  - `in_data` is not required to be stable beyond that edge.
- **State machine:**
  - **IDLE:** if hold holds a word, move it to `sr`, else bypass an accepted word straight into `sr`. Go to SHIFT and clear `bit_cnt`.
  - **SHIFT:** `load`=1. `data_out` = `sr[WIDTH-1]` (MSB_FIRST=1) or `sr[0]`. Shift by one each cycle and increment `bit_cnt`. On `bit_cnt==WIDTH-1`, assert `done` and go to GAP (GAP>0) or to reload/IDLE (GAP==0).
  - **GAP:** `load`=0 and `data_out`=0 for exactly GAP cycles. Then go to SHIFT with the hold word if `hold_valid`, else IDLE.
- **Accepts while busy:** a word accepted in SHIFT or GAP goes into hold.
- **Hold drain:** the cycle hold drains into `sr`, `hold_valid` clears and `in_ready` rises the following cycle. There is no same-edge refill.
- **GAP==0 with hold full at last bit:** the next word's first bit follows the last bit immediately, so `load` stays continuously high.
- **IDLE:** `load`=0 and `data_out`=0.
- **Reset values:** `load`=0, `data_out`=0, `busy`=0, `done`=0, `in_ready`=1, state IDLE.
- **Reset asserted mid-word:** the in-flight word and the held word are discarded. `load` falls asynchronously.

## Timing
- All outputs except `in_ready` are registered.
- **First-bit latency:** a word accepted at edge *k* in IDLE with hold empty presents its first bit with `load`=1 after edge *k*. `sipo_1` samples it at edge *k+1*.
- **Word duration:** each word holds `load` high for exactly WIDTH consecutive cycles.
- **Word-to-word spacing:** successive queued words are separated by exactly GAP low cycles.
- **Sustained throughput:** WIDTH/(WIDTH+GAP) bits per cycle.
- **`done`** is high on the cycle after the edge that launched bit WIDTH-1, aligned with that bit.

## Structure
- Package `piso_pkg`:
  - state enum `piso_state_t` {IDLE, SHIFT, GAP};
  - `localparam PISO_WIDTH_DEF = 8`.
- Sub-module `piso_hold`: single-entry buffer with `wr_en`, `rd_en`, `din`, `dout`, `valid`, and the same `clk`/`rst`.
- FSM, counters and shifter stay in `piso_tx`.

## Test plan
- **Single byte:** after reset, send 0xF0. `data_out` = 1,1,1,1,0,0,0,0 with `load` high 8 cycles, `done` on the 8th bit, then 2 low cycles, `busy`=0.
- **Queued bytes, GAP=2:** send 0xAA, then 0xFF while busy. `in_ready` is low from acceptance of 0xFF until it drains. 0xFF's first bit starts exactly 2 cycles after 0xAA's last bit.
- **GAP=0:** send 0x5A and 0xC3 back-to-back. `load` stays high 16 consecutive cycles; bits are 01011010 then 11000011.
- **MSB_FIRST=0:** send 0x01. The first serial bit is 1 and the next 7 are 0.
- **Reset mid-operation:** assert `rst` low mid-word after the 3rd bit with hold full. `load` drops immediately. After release, `in_ready`=1, `busy`=0, and no residual bits are emitted.
- **Loopback:** connect to `sipo_1`. For 0xF0, 0xAA and 0xFF, `sipo_1` `data_out` equals each byte on the cycle after `done`.
